// File: rtl/cond_flag_unit.sv
// ARM condition-flag unit: architectural {N,Z,C,V} register with split write
// enables, condition evaluation, latched condition gating and a flag save slot.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       FlagSave,
  input  logic       FlagRestore,
  output logic [3:0] Flags,
  output logic       CarryIn,
  output logic       CondEx,
  output logic       CondExReg,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flags_r;
  logic [3:0] saved_r;
  logic       condex_r;
  logic [3:0] flags_next_s;
  logic [3:0] saved_next_s;
  logic       condex_s;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flg);
    logic n;
    logic z;
    logic c;
    logic v;
    logic res;
    {n, z, c, v} = flg;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Condition evaluated against registered flags only; no ALU bypass.
  always_comb begin
    condex_s = cond_eval(Cond, flags_r);
  end

  // Next flag and save-slot values; restore overrides any conditional write.
  always_comb begin
    flags_next_s = flags_r;
    saved_next_s = saved_r;
    if (FlagRestore) begin
      flags_next_s = saved_r;
    end else begin
      if (FlagW[1] && condex_r) begin
        flags_next_s[3:2] = ALUFlags[3:2];
      end else begin
        flags_next_s[3:2] = flags_r[3:2];
      end
      if (FlagW[0] && condex_r) begin
        flags_next_s[1:0] = ALUFlags[1:0];
      end else begin
        flags_next_s[1:0] = flags_r[1:0];
      end
    end
    if (FlagSave) begin
      saved_next_s = flags_r;
    end else begin
      saved_next_s = saved_r;
    end
  end

  // State registers: flags, save slot and latched condition result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r  <= FLAG_RESET;
      saved_r  <= FLAG_RESET;
      condex_r <= 1'b0;
    end else begin
      flags_r <= flags_next_s;
      saved_r <= saved_next_s;
      if (CondLatch) begin
        condex_r <= condex_s;
      end
    end
  end

  assign Flags     = flags_r;
  assign CarryIn   = flags_r[1];
  assign CondEx    = condex_s;
  assign CondExReg = condex_r;
  assign PCWrite   = NextPC | (PCS & condex_r);
  assign RegWrite  = RegW & condex_r;
  assign MemWrite  = MemW & condex_r;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: directed plan steps followed by random
// traffic, checked against a behavioural flag model.
module tb_cond_flag_unit;

  localparam logic [3:0] FLAG_RST = 4'b0000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond = 4'b1110;
  logic [3:0] ALUFlags = 4'b0000;
  logic [1:0] FlagW = 2'b00;
  logic       CondLatch = 1'b0;
  logic       PCS = 1'b0;
  logic       NextPC = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       FlagSave = 1'b0;
  logic       FlagRestore = 1'b0;
  logic [3:0] Flags;
  logic       CarryIn, CondEx, CondExReg, PCWrite, RegWrite, MemWrite;

  cond_flag_unit #(.FLAG_RESET(FLAG_RST)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .FlagSave(FlagSave), .FlagRestore(FlagRestore), .Flags(Flags), .CarryIn(CarryIn),
    .CondEx(CondEx), .CondExReg(CondExReg), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] flags;
    logic       condex;
    logic       cr;
    logic       pcw;
    logic       rw;
    logic       mw;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [3:0] m_flags = FLAG_RST;
  logic [3:0] m_saved = FLAG_RST;
  logic       m_cr = 1'b0;

  // Reference condition: ARM pairs each base test with its complement in bit 0.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
  endtask

  // Monitor: outputs are sampled mid-cycle and matched against the queued model result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("Flags", Flags, e.flags);
        cmp("CarryIn", {3'b000, CarryIn}, {3'b000, e.flags[1]});
        cmp("CondEx", {3'b000, CondEx}, {3'b000, e.condex});
        cmp("CondExReg", {3'b000, CondExReg}, {3'b000, e.cr});
        cmp("PCWrite", {3'b000, PCWrite}, {3'b000, e.pcw});
        cmp("RegWrite", {3'b000, RegWrite}, {3'b000, e.rw});
        cmp("MemWrite", {3'b000, MemWrite}, {3'b000, e.mw});
      end
    end
  end

  task automatic step(input logic rst_v, input logic [3:0] c, input logic [3:0] alu,
                      input logic [1:0] fw, input logic cl, input logic pcs_v,
                      input logic npc_v, input logic rw_v, input logic mw_v,
                      input logic sv_v, input logic rs_v);
    exp_t e;
    logic [3:0] nf;
    @(posedge clk);
    #1;
    reset = rst_v; Cond = c; ALUFlags = alu; FlagW = fw; CondLatch = cl;
    PCS = pcs_v; NextPC = npc_v; RegW = rw_v; MemW = mw_v;
    FlagSave = sv_v; FlagRestore = rs_v;
    if (!rst_v) begin
      m_flags = FLAG_RST; m_saved = FLAG_RST; m_cr = 1'b0;
    end
    e.flags = m_flags;
    e.condex = ref_cond(c, m_flags);
    e.cr = m_cr;
    e.pcw = npc_v | (pcs_v & m_cr);
    e.rw = rw_v & m_cr;
    e.mw = mw_v & m_cr;
    sb.push_back(e);
    if (rst_v) begin
      nf = m_flags;
      if (rs_v) nf = m_saved;
      else begin
        if (fw[1] && m_cr) nf[3:2] = alu[3:2];
        if (fw[0] && m_cr) nf[1:0] = alu[1:0];
      end
      if (sv_v) m_saved = m_flags;
      if (cl) m_cr = ref_cond(c, m_flags);
      m_flags = nf;
    end
  endtask

  task automatic idle(input logic [3:0] c);
    step(1'b1, c, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] fw, input logic [3:0] alu);
    step(1'b1, 4'b1110, alu, fw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Direct check of a DUT output against a plan constant in the current cycle.
  task automatic chk(input string name, input int sel, input logic [3:0] want);
    @(negedge clk);
    case (sel)
      0: cmp(name, Flags, want);
      1: cmp(name, {3'b000, CondEx}, want);
      2: cmp(name, {3'b000, CondExReg}, want);
      default: cmp(name, {1'b0, PCWrite, RegWrite, MemWrite}, want);
    endcase
  endtask

  initial begin
    // Plan 1: reset, EQ on zero flags fails
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1_condex", 1, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1_condexreg", 2, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1_gated", 3, 4'b0100);
    // Plan 2: AL latch, full write, EQ/HI
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(2'b11, 4'b0110);
    idle(4'b1110); chk("p2_flags", 0, 4'b0110);
    idle(4'b0000); chk("p2_eq", 1, 4'b0001);
    idle(4'b1000); chk("p2_hi", 1, 4'b0000);
    // Plan 3: split writes from zero flags
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4'b1110); chk("p3_zero", 0, 4'b0000);
    wr(2'b10, 4'b1111);
    idle(4'b1110); chk("p3_nz", 0, 4'b1100);
    wr(2'b01, 4'b0011);
    idle(4'b1110); chk("p3_cv", 0, 4'b1111);
    // Plan 4: failed condition blocks writes and strobes
    wr(2'b11, 4'b0100);
    step(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p4_ne", 1, 4'b0000);
    step(1'b1, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("p4_gated", 3, 4'b0000);
    idle(4'b1110); chk("p4_hold", 0, 4'b0100);
    // Plan 5: signed conditions
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(2'b11, 4'b1001);
    idle(4'b1010); chk("p5_ge1", 1, 4'b0001);
    idle(4'b1011); chk("p5_lt0", 1, 4'b0000);
    wr(2'b11, 4'b1000);
    idle(4'b1010); chk("p5_ge0", 1, 4'b0000);
    idle(4'b1011); chk("p5_lt1", 1, 4'b0001);
    idle(4'b1100); chk("p5_gt0", 1, 4'b0000);
    idle(4'b1101); chk("p5_le1", 1, 4'b0001);
    wr(2'b11, 4'b0100);
    idle(4'b1100); chk("p5_gt0z", 1, 4'b0000);
    idle(4'b1101); chk("p5_le1z", 1, 4'b0001);
    // Plan 6: save, restore priority, swap, async reset
    wr(2'b11, 4'b1010);
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wr(2'b11, 4'b0101);
    step(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4'b1110); chk("p6_restore", 0, 4'b1010);
    wr(2'b11, 4'b0011);
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4'b1110); chk("p6_swap_f", 0, 4'b1010);
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4'b1110); chk("p6_swap_s", 0, 4'b0011);
    step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("p6_rst_gated", 3, 4'b0000);
    step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4'b1110); chk("p6_rst_saved", 0, 4'b0000);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
